exchanger_responder: RTL

EXCHANGER_RESPONDER -- requirements
Module: exchanger_responder

---
 rtl/exchanger_responder.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/exchanger_responder.sv
`default_nettype none
// ============================================================================
// Module      : exchanger_responder
// Description : Polls a shared exchanger mailbox, offers new commands to local
//               logic and writes back result (word9) then ack (word8).
//               Optional response timeout: define EXCHANGER_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module exchanger_responder #(
    parameter logic [31:0] POLL_DIV    = 32'd1000,
    parameter int unsigned RD_LAT      = 1,
    parameter logic [31:0] TIMEOUT_CYC = 32'd1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [3:0]  nios_sel,
    input  logic [31:0] nios_data_from,
    output logic [31:0] nios_data_to,
    output logic        nios_wr,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [7:0]  cmd_op,
    output logic [31:0] cmd_arg,
    input  logic        rsp_valid,
    input  logic [7:0]  rsp_status,
    input  logic [31:0] rsp_data,
    output logic        busy
);

    localparam logic [2:0] c_S_IDLE     = 3'd0;
    localparam logic [2:0] c_S_RD_HDR   = 3'd1;
    localparam logic [2:0] c_S_RD_ARG   = 3'd2;
    localparam logic [2:0] c_S_DISPATCH = 3'd3;
    localparam logic [2:0] c_S_WAIT_RSP = 3'd4;
    localparam logic [2:0] c_S_WR_DATA  = 3'd5;
    localparam logic [2:0] c_S_WR_ACK   = 3'd6;

    logic [2:0]  r_state;
    logic [31:0] r_poll_cnt;
    logic [31:0] r_lat_cnt;
    logic [7:0]  r_last_seq;
    logic [7:0]  r_seq;
    logic [7:0]  r_op;
    logic [7:0]  r_status;
    logic        w_rd_done;

    assign w_rd_done = (r_lat_cnt == RD_LAT);

`ifdef EXCHANGER_TIMEOUT_EN
    logic [31:0] r_timer;
    logic        w_timeout;
    assign w_timeout = (r_timer == TIMEOUT_CYC - 32'd1);
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT_CYC;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_S_IDLE;
            r_poll_cnt   <= 32'd0;
            r_lat_cnt    <= 32'd0;
            r_last_seq   <= 8'h00;
            r_seq        <= 8'h00;
            r_op         <= 8'h00;
            r_status     <= 8'h00;
            nios_sel     <= 4'd0;
            nios_data_to <= 32'd0;
            nios_wr      <= 1'b0;
            cmd_valid    <= 1'b0;
            cmd_op       <= 8'h00;
            cmd_arg      <= 32'd0;
            busy         <= 1'b0;
`ifdef EXCHANGER_TIMEOUT_EN
            r_timer      <= 32'd0;
`endif
        end else begin
`ifdef EXCHANGER_TIMEOUT_EN
            r_timer <= r_timer + 32'd1;
`endif
            case (r_state)
                c_S_IDLE: begin
                    if (r_poll_cnt == POLL_DIV - 32'd1) begin
                        r_poll_cnt <= 32'd0;
                        r_lat_cnt  <= 32'd0;
                        nios_sel   <= 4'd0;
                        r_state    <= c_S_RD_HDR;
                    end else begin
                        r_poll_cnt <= r_poll_cnt + 32'd1;
                    end
                end
                c_S_RD_HDR: begin
                    if (w_rd_done) begin
                        r_lat_cnt <= 32'd0;
                        if (nios_data_from[31:24] == r_last_seq) begin
                            r_state <= c_S_IDLE;
                        end else begin
                            r_seq    <= nios_data_from[31:24];
                            r_op     <= nios_data_from[23:16];
                            busy     <= 1'b1;
                            nios_sel <= 4'd1;
                            r_state  <= c_S_RD_ARG;
                        end
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 32'd1;
                    end
                end
                c_S_RD_ARG: begin
                    if (w_rd_done) begin
                        r_lat_cnt <= 32'd0;
                        cmd_arg   <= nios_data_from;
                        // Opcode 0 is a no-op: answered locally, never offered.
                        if (r_op == 8'h00) begin
                            r_status     <= 8'hFF;
                            nios_sel     <= 4'd9;
                            nios_wr      <= 1'b1;
                            nios_data_to <= 32'd0;
                            r_state      <= c_S_WR_DATA;
                        end else begin
                            cmd_op    <= r_op;
                            cmd_valid <= 1'b1;
`ifdef EXCHANGER_TIMEOUT_EN
                            r_timer   <= 32'd0;
`endif
                            r_state   <= c_S_DISPATCH;
                        end
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 32'd1;
                    end
                end
                c_S_DISPATCH: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        r_state   <= c_S_WAIT_RSP;
                    end
`ifdef EXCHANGER_TIMEOUT_EN
                    else if (w_timeout) begin
                        cmd_valid    <= 1'b0;
                        r_status     <= 8'hFE;
                        nios_sel     <= 4'd9;
                        nios_wr      <= 1'b1;
                        nios_data_to <= 32'd0;
                        r_state      <= c_S_WR_DATA;
                    end
`endif
                end
                c_S_WAIT_RSP: begin
                    if (rsp_valid) begin
                        r_status     <= rsp_status;
                        nios_sel     <= 4'd9;
                        nios_wr      <= 1'b1;
                        nios_data_to <= rsp_data;
                        r_state      <= c_S_WR_DATA;
                    end
`ifdef EXCHANGER_TIMEOUT_EN
                    else if (w_timeout) begin
                        r_status     <= 8'hFE;
                        nios_sel     <= 4'd9;
                        nios_wr      <= 1'b1;
                        nios_data_to <= 32'd0;
                        r_state      <= c_S_WR_DATA;
                    end
`endif
                end
                c_S_WR_DATA: begin
                    nios_sel     <= 4'd8;
                    nios_wr      <= 1'b1;
                    nios_data_to <= {r_seq, r_status, 16'h0000};
                    r_state      <= c_S_WR_ACK;
                end
                c_S_WR_ACK: begin
                    r_last_seq   <= r_seq;
                    nios_sel     <= 4'd0;
                    nios_wr      <= 1'b0;
                    nios_data_to <= 32'd0;
                    busy         <= 1'b0;
                    r_state      <= c_S_IDLE;
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
